// File: rtl/wb2core.sv
// wb2core: Wishbone B4 pipelined slave bridged onto a req/gnt/rvalid core memory port.
// One request slot, registered responses, outstanding-count tracking and post-abort discard.
module wb2core #(
    parameter int PENDING = 4,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic            wb_we_i,
    input  logic [AW-1:0]   wb_adr_i,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic [DW-1:0]   wb_dat_i,
    output logic            wb_stall_o,
    output logic            wb_ack_o,
    output logic            wb_err_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic            core_req_o,
    input  logic            core_gnt_i,
    output logic            core_we_o,
    output logic [DW/8-1:0] core_be_o,
    output logic [AW-1:0]   core_addr_o,
    output logic [DW-1:0]   core_wdata_o,
    input  logic            core_rvalid_i,
    input  logic            core_err_i,
    input  logic [DW-1:0]   core_rdata_i
);
    localparam int CW = $clog2(PENDING + 1);
    logic          slot_v, ack_q, err_q, accept, rv, rsp;
    logic [CW-1:0] cnt, disc, cnt_d, disc_d;
    assign core_req_o = slot_v;
    assign wb_stall_o = (slot_v & ~core_gnt_i) | (cnt == CW'(PENDING)) | (disc != '0);
    assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
    // a stray rvalid with nothing outstanding must not underflow cnt
    assign rv         = core_rvalid_i & (cnt != '0);
    assign rsp        = rv & (disc == '0) & wb_cyc_i;
    assign wb_ack_o   = ack_q & wb_cyc_i;
    assign wb_err_o   = err_q & wb_cyc_i;
    always_comb begin
        cnt_d  = cnt + CW'(accept) - CW'(rv);
        disc_d = (!wb_cyc_i && cnt != '0) ? cnt - CW'(rv) : (rv && disc != '0) ? disc - CW'(1) : disc;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_v       <= 1'b0;
            core_we_o    <= 1'b0;
            core_be_o    <= '0;
            core_addr_o  <= '0;
            core_wdata_o <= '0;
            cnt          <= '0;
            disc         <= '0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            wb_dat_o     <= '0;
        end else begin
            cnt   <= cnt_d;
            disc  <= disc_d;
            ack_q <= rsp & ~core_err_i;
            err_q <= rsp & core_err_i;
            if (rsp) wb_dat_o <= core_rdata_i;
            if (accept) begin
                slot_v       <= 1'b1;
                core_we_o    <= wb_we_i;
                core_be_o    <= wb_sel_i;
                core_addr_o  <= wb_adr_i;
                core_wdata_o <= wb_dat_i;
            end else if (core_gnt_i) begin
                slot_v <= 1'b0;
            end
        end
    end
    assert property (@(posedge clk_i) disable iff (!rst_ni) core_rvalid_i |-> cnt != '0);
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(wb_ack_o && wb_err_o));
endmodule

// File: tb/tb_wb2core.sv
// tb_wb2core: randomized bench with a memory-style device model and an in-order response scoreboard.
module tb_wb2core;
    localparam int PENDING = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    logic clk = 1'b0, rst_n = 1'b0;
    logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [AW-1:0] adr = '0;
    logic [SW-1:0] sel = '0;
    logic [DW-1:0] wdat = '0;
    logic stall, ack, err, req, cwe;
    logic [DW-1:0] rdat, cwdata;
    logic [SW-1:0] be;
    logic [AW-1:0] caddr;
    logic gnt = 1'b0, rvalid = 1'b0, cerr = 1'b0;
    logic [DW-1:0] crdata = '0;

    wb2core #(.PENDING(PENDING), .AW(AW), .DW(DW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(wdat), .wb_stall_o(stall), .wb_ack_o(ack),
        .wb_err_o(err), .wb_dat_o(rdat), .core_req_o(req), .core_gnt_i(gnt), .core_we_o(cwe),
        .core_be_o(be), .core_addr_o(caddr), .core_wdata_o(cwdata), .core_rvalid_i(rvalid),
        .core_err_i(cerr), .core_rdata_i(crdata));

    always #5 clk = ~clk;

    typedef struct { logic we; logic err; logic [DW-1:0] dat; } exp_t;
    typedef struct { logic we; logic [AW-1:0] adr; logic [SW-1:0] sel; logic [DW-1:0] dat; } req_t;
    typedef struct { int due; logic err; logic [DW-1:0] dat; } rsp_t;
    exp_t exp_q[$];
    req_t req_q[$];
    rsp_t dev_q[$];
    exp_t m;
    logic [DW-1:0] ref_mem[int];
    logic [DW-1:0] dev_mem[int];
    int checks = 0, errors = 0, cyc_n = 0, n_acc = 0, n_gnt = 0, n_ack = 0, n_err = 0;
    int gnt_pct = 100, rv_pct = 100, lat_min = 1, lat_max = 1;
    bit rv_hold = 1'b0, acc_now = 1'b0;

    function automatic logic [DW-1:0] init_word(input int i);
        return DW'(32'hC0DE_0000 + i);
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw, input logic [SW-1:0] s);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < SW; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string n, input logic [DW-1:0] got, input logic [DW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", n, got, want);
        end
    endtask

    // one clock: decide accept/grant/rvalid at negedge, then drive device inputs after posedge
    task automatic step();
        int i;
        exp_t e;
        req_t r;
        rsp_t d;
        @(negedge clk);
        acc_now = 1'b0;
        if (rst_n) begin
            if (rvalid) void'(dev_q.pop_front());
            if (req && gnt) begin
                n_gnt++;
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_grant addr=%h", caddr);
                end else begin
                    r = req_q.pop_front();
                    chk("core_we", DW'(cwe), DW'(r.we));
                    chk("core_addr", caddr, r.adr);
                    chk("core_be", DW'(be), DW'(r.sel));
                    if (r.we) chk("core_wdata", cwdata, r.dat);
                end
                i = int'(caddr[11:2]);
                d.due = cyc_n + int'($urandom_range(lat_max, lat_min));
                d.err = caddr[12];
                d.dat = dev_mem.exists(i) ? dev_mem[i] : init_word(i);
                if (cwe && !d.err) dev_mem[i] = merge(d.dat, cwdata, be);
                if (d.err) d.dat = $urandom;
                dev_q.push_back(d);
            end
            if (cyc && stb && !stall) begin
                acc_now = 1'b1;
                n_acc++;
                r.we = we; r.adr = adr; r.sel = sel; r.dat = wdat;
                req_q.push_back(r);
                i = int'(adr[11:2]);
                e.we = we;
                e.err = adr[12];
                e.dat = ref_mem.exists(i) ? ref_mem[i] : init_word(i);
                if (we && !e.err) ref_mem[i] = merge(e.dat, wdat, sel);
                exp_q.push_back(e);
            end
            if (!cyc) exp_q.delete();
        end
        @(posedge clk);
        cyc_n++;
        #1;
        if (acc_now) stb = 1'b0;
        gnt = ($urandom_range(99) < gnt_pct);
        rvalid = rst_n && !rv_hold && dev_q.size() > 0 && dev_q[0].due <= cyc_n && $urandom_range(99) < rv_pct;
        cerr = rvalid ? dev_q[0].err : 1'($urandom);
        crdata = rvalid ? dev_q[0].dat : $urandom;
        #1;
    endtask

    task automatic rand_req(input bit wr, input bit bad);
        we = wr;
        adr = '0;
        adr[12] = bad;
        adr[5:2] = 4'($urandom);
        sel = 4'($urandom_range(15, 1));
        wdat = $urandom;
        stb = 1'b1;
    endtask

    task automatic wait_acc(input string n);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!acc_now && k < 200);
        if (!acc_now) begin
            checks++;
            errors++;
            $display("FAIL %s accept timeout", n);
            stb = 1'b0;
        end
    endtask

    task automatic drain(input string n);
        int k;
        k = 0;
        while ((stb || exp_q.size() != 0 || dev_q.size() != 0 || req_q.size() != 0) && k < 500) begin
            step();
            k++;
        end
        step();
        step();
        chk({n, "_drained"}, DW'(exp_q.size() + dev_q.size() + req_q.size()), '0);
    endtask

    always @(negedge clk) begin
        if (rst_n && (ack || err)) begin
            chk("ack_err_excl", DW'(ack && err), '0);
            if (ack) n_ack++;
            else n_err++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp ack=%0b err=%0b dat=%h", ack, err, rdat);
            end else begin
                m = exp_q.pop_front();
                chk("rsp_kind_err", DW'(err), DW'(m.err));
                if (!m.we && !m.err) chk("rsp_rdata", rdat, m.dat);
            end
        end
    end

    initial begin
        int a0, n0;
        logic [AW-1:0] hold;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_req", DW'(req), '0);
        chk("rst_ack", DW'(ack), '0);
        chk("rst_err", DW'(err), '0);
        chk("rst_dat", rdat, '0);
        chk("rst_stall", DW'(stall), '0);
        rst_n = 1'b1;
        cyc = 1'b1;
        ref_mem[64] = 32'hDEADBEEF;
        dev_mem[64] = 32'hDEADBEEF;
        lat_min = 2;
        lat_max = 2;
        a0 = n_ack;
        we = 1'b0; adr = 32'h100; sel = 4'hF; stb = 1'b1;
        wait_acc("single");
        chk("single_req_lat", DW'(req), 32'd1);
        drain("single");
        chk("single_acks", DW'(n_ack - a0), 32'd1);
        chk("single_dat", rdat, 32'hDEADBEEF);

        lat_min = 1;
        lat_max = 1;
        a0 = n_ack;
        for (int i = 0; i < 8; i++) begin
            rand_req(1'b1, 1'b0);
            chk("burst_nostall", DW'(stall), '0);
            step();
            chk("burst_accept", DW'(acc_now), 32'd1);
        end
        drain("burst");
        chk("burst_acks", DW'(n_ack - a0), 32'd8);

        gnt_pct = 0;
        rand_req(1'b0, 1'b0);
        wait_acc("bp");
        hold = caddr;
        n0 = n_gnt;
        rand_req(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_stall", DW'(stall), 32'd1);
            chk("bp_req", DW'(req), 32'd1);
            chk("bp_addr", caddr, hold);
            step();
        end
        stb = 1'b0;
        gnt = 1'b1;
        #1;
        step();
        chk("bp_one_grant", DW'(n_gnt - n0), 32'd1);
        chk("bp_req_drop", DW'(req), '0);
        gnt_pct = 100;
        drain("bp");

        rv_hold = 1'b1;
        n0 = n_acc;
        for (int i = 0; i < 8; i++) begin
            if (!stb) rand_req(1'($urandom), 1'b0);
            step();
        end
        chk("full_accepts", DW'(n_acc - n0), 32'd4);
        chk("full_stall", DW'(stall), 32'd1);
        rv_hold = 1'b0;
        step();
        chk("full_stall_rv", DW'(stall), 32'd1);
        n0 = n_acc;
        step();
        chk("full_free", DW'(stall), '0);
        rv_hold = 1'b1;
        step();
        chk("full_rv_and_acc", DW'(acc_now), 32'd1);
        rand_req(1'($urandom), 1'b0);
        chk("full_one_left", DW'(stall), '0);
        step();
        rand_req(1'($urandom), 1'b0);
        chk("full_again", DW'(stall), 32'd1);
        chk("full_acc_count", DW'(n_acc - n0), 32'd2);
        rv_hold = 1'b0;
        drain("full");

        rv_hold = 1'b1;
        a0 = n_ack + n_err;
        for (int i = 0; i < 3; i++) begin
            rand_req(1'b0, 1'b0);
            wait_acc("abort_fill");
        end
        step();
        step();
        cyc = 1'b0;
        stb = 1'b0;
        step();
        cyc = 1'b1;
        rand_req(1'b0, 1'b0);
        chk("abort_stall", DW'(stall), 32'd1);
        step();
        chk("abort_stall2", DW'(stall), 32'd1);
        rv_hold = 1'b0;
        wait_acc("abort_resume");
        chk("abort_no_ack", DW'(n_ack + n_err - a0), '0);
        drain("abort");
        chk("abort_resume_rsp", DW'(n_ack + n_err - a0), 32'd1);

        a0 = n_err;
        n0 = n_ack;
        rand_req(1'b0, 1'b1);
        wait_acc("err");
        drain("err");
        chk("err_seen", DW'(n_err - a0), 32'd1);
        chk("err_no_ack", DW'(n_ack - n0), '0);

        for (int blk = 0; blk < 6; blk++) begin
            gnt_pct = $urandom_range(100, 30);
            rv_pct = $urandom_range(100, 30);
            lat_max = $urandom_range(4, 1);
            for (int c = 0; c < 150; c++) begin
                if (!stb && $urandom_range(99) < 60) rand_req(1'($urandom), $urandom_range(99) < 10);
                if ($urandom_range(199) == 0) begin
                    cyc = 1'b0;
                    stb = 1'b0;
                    step();
                    cyc = 1'b1;
                end
                step();
            end
            drain("rand");
        end

        gnt_pct = 70;
        for (int c = 0; c < 20; c++) begin
            if (!stb) rand_req(1'($urandom), 1'b0);
            step();
        end
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_req", DW'(req), '0);
        chk("rst_mid_ack", DW'(ack), '0);
        chk("rst_mid_err", DW'(err), '0);
        chk("rst_mid_dat", rdat, '0);
        stb = 1'b0;
        cyc = 1'b0;
        rvalid = 1'b0;
        gnt = 1'b0;
        exp_q.delete();
        dev_q.delete();
        req_q.delete();
        ref_mem = dev_mem;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        cyc = 1'b1;
        gnt_pct = 100;
        for (int i = 0; i < 6; i++) begin
            rand_req(1'($urandom), 1'b0);
            wait_acc("post_rst");
        end
        drain("post_rst");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
